fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the DAPA2014 core.
- Owns the program counter and drives the address of the combinational 8-bit-address / 16-bit-data program memory.
- Captures each returned word into a one-entry instruction register handed to decode with a valid/ready handshake.
- Folds unconditional JMP locally, accepts taken-branch redirects from execute, and halts the front end on STOP.

Parameters:
AW, 8, program address width
DW, 16, instruction width
RESET_PC, 8'h00, PC value after reset
OP_JMP, 5'b00111, opcode (bits 15:11) of JMP; target in bits 7:0
OP_STOP, 5'b10111, opcode of STOP

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_addr  out  AW  program memory address; always equals pc
mem_data  in  DW  program memory word for mem_addr, same cycle (combinational)
ir  out  DW  instruction presented to decode
ir_pc  out  AW  address ir was fetched from
ir_valid  out  1  ir holds an instruction for decode
ir_ready  in  1  decode accepts ir this cycle when ir_valid=1
redirect  in  1  taken branch from execute, one-cycle pulse
redirect_addr  in  AW  branch target
halted  out  1  STOP has been accepted by decode; front end frozen
fold_cnt  out  8  count of JMPs folded (debug), wraps

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fold_cnt=0, state=RUN.
  - Reset mid-operation discards everything immediately.
- States:
  - RUN: fetching.
  - STOP_PEND: STOP is in ir, waiting for acceptance.
  - HALTED: terminal until reset.
- slot_free = !ir_valid | ir_ready.
- Priority per cycle: redirect > fetch.
- Redirect (any state except HALTED):
  - pc<=redirect_addr, ir_valid<=0, state<=RUN.
  - This applies even if ir_valid=1 and ir_ready=1 in the same cycle: the accepted instruction is consumed, and no new instruction is captured.
  - A redirect in STOP_PEND cancels the speculative STOP.
  - A redirect in HALTED is ignored.
- RUN, no redirect, slot_free:
  - mem_data opcode == OP_JMP: pc<=mem_data[7:0], ir_valid<=0 (or cleared by acceptance), fold_cnt+=1. The JMP never reaches decode; zero-bubble fold.
  - mem_data opcode == OP_STOP: ir<=mem_data, ir_pc<=pc, ir_valid<=1, pc unchanged, state<=STOP_PEND.
  - Otherwise: ir<=mem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
- RUN, !slot_free: hold pc, ir and ir_valid (stall).
- STOP_PEND: no fetch; on ir_valid & ir_ready with no redirect, ir_valid<=0, halted<=1, state<=HALTED.
- HALTED: all registers hold; only reset exits.
- Latency:
  - Instruction at address A is in ir one cycle after pc=A with slot_free.
  - Sustained throughput is 1 instruction/cycle while ir_ready=1.
- pc increment is modulo 2^AW: 8'hFF -> 8'h00.
- JMP to its own address: folds every cycle, ir_valid stays 0, fold_cnt increments every cycle and wraps 8'hFF -> 8'h00.
- mem_addr is a register output (pc), so there is no combinational path from ir_ready or redirect to mem_addr.

Decomposition:
- Shared package dapa_pkg holds:
  - AW/DW defaults
  - opcode constants OP_JMP, OP_STOP, OP_BRZS=5'b00110
  - field slices: opcode [15:11], reg [10:8], imm/target [7:0]
  - fetch state encoding (RUN, STOP_PEND, HALTED)
- One natural sub-module, fetch_predecode: a combinational block that classifies mem_data into is_jmp / is_stop / target. Everything else stays in fetch_unit.

Test Plan:
- Multiply program (0:LDI R0,$08 ... 3:SUBI, 4:BRZS 7, 6:JMP 3, 8:STOP), ir_ready=1, execute model redirects on BRZS when R1 reaches 0:
  - Decode sees the sequence 0,1,2,(3,4,5)x15,3,4,7,8.
  - Address 6 never appears on ir_pc; fold_cnt=15.
  - halted=1 after address 8 is accepted.
- Hold ir_ready=0 for 3 cycles with ir_pc=1: ir, ir_pc and mem_addr=2 are stable; release ir_ready -> 2 arrives next cycle.
- STOP in ir (STOP_PEND), assert redirect with redirect_addr=8'h05 before acceptance: ir_valid=0, state=RUN, next ir_pc=5, halted stays 0.
- Redirect in the same cycle as acceptance of ir_pc=4 (redirect_addr=8'h07): 4 is consumed, and next ir_pc=7, not 5.
- Straight-line code at 8'hFE, 8'hFF: the next fetch is at 8'h00, with no spurious redirect.
- rst_n low while pc=8'h05 and ir_valid=1: outputs clear asynchronously, before the next clk edge; after release, the first ir_pc is 8'h00.

Source files
------------

// File: rtl/dapa_pkg.sv
// Shared definitions for the DAPA2014 core: width defaults, opcode constants,
// instruction field slices and the fetch state encoding.
package dapa_pkg;

  localparam int unsigned AW_DEFAULT = 8;
  localparam int unsigned DW_DEFAULT = 16;

  localparam logic [4:0] OPC_BRZS = 5'b00110;
  localparam logic [4:0] OPC_JMP  = 5'b00111;
  localparam logic [4:0] OPC_STOP = 5'b10111;

  typedef enum logic [1:0] {
    StRun,
    StStopPend,
    StHalted
  } fetch_state_e;

  function automatic logic [4:0] get_opcode(input logic [15:0] word);
    return word[15:11];
  endfunction

  function automatic logic [2:0] get_reg(input logic [15:0] word);
    return word[10:8];
  endfunction

  function automatic logic [7:0] get_imm(input logic [15:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational classifier for the word returned by program memory.
// Ports:
//   word    - raw instruction word from program memory
//   is_jmp  - word is an unconditional JMP (folded in fetch)
//   is_stop - word is a STOP
//   target  - jump target field, zero-extended to AW
module fetch_predecode
  import dapa_pkg::*;
#(
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter logic [4:0]  OP_JMP  = OPC_JMP,
  parameter logic [4:0]  OP_STOP = OPC_STOP
) (
  input  logic [DW-1:0] word,
  output logic          is_jmp,
  output logic          is_stop,
  output logic [AW-1:0] target
);

  logic [4:0] opcode;
  // Register field plays no part in fetch classification.
  logic       unused_reg;

  assign opcode     = get_opcode(word[15:0]);
  assign unused_reg = ^get_reg(word[15:0]);
  assign is_jmp     = (opcode == OP_JMP);
  assign is_stop    = (opcode == OP_STOP);
  assign target     = AW'(get_imm(word[15:0]));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the DAPA2014 core. Owns the PC, drives the
// combinational program memory, holds a one-entry instruction register for
// decode, folds JMP locally, takes branch redirects and halts on STOP.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   mem_addr / mem_data  - program memory address (== pc) and returned word
//   ir, ir_pc, ir_valid  - instruction, its address, valid towards decode
//   ir_ready             - decode accepts ir this cycle
//   redirect(_addr)      - taken-branch pulse and target from execute
//   halted               - STOP accepted; front end frozen until reset
//   fold_cnt             - number of folded JMPs (wraps)
module fetch_unit
  import dapa_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEFAULT,
  parameter int unsigned   DW       = DW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [4:0]    OP_JMP   = OPC_JMP,
  parameter logic [4:0]    OP_STOP  = OPC_STOP
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          halted,
  output logic [7:0]    fold_cnt
);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [AW-1:0] ir_pc_q;
  logic          ir_valid_q;
  logic          halted_q;
  logic [7:0]    fold_cnt_q;

  logic          is_jmp;
  logic          is_stop;
  logic [AW-1:0] jmp_target;
  logic          slot_free;

  fetch_predecode #(
    .AW      (AW),
    .DW      (DW),
    .OP_JMP  (OP_JMP),
    .OP_STOP (OP_STOP)
  ) u_predecode (
    .word    (mem_data),
    .is_jmp  (is_jmp),
    .is_stop (is_stop),
    .target  (jmp_target)
  );

  assign slot_free = !ir_valid_q || ir_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          // Redirect wins; an instruction accepted this cycle is still consumed.
          if (redirect) begin
            pc_q       <= redirect_addr;
            ir_valid_q <= 1'b0;
          end else if (slot_free) begin
            if (is_jmp) begin
              pc_q       <= jmp_target;
              ir_valid_q <= 1'b0;
              fold_cnt_q <= fold_cnt_q + 8'd1;
            end else begin
              ir_q       <= mem_data;
              ir_pc_q    <= pc_q;
              ir_valid_q <= 1'b1;
              if (is_stop) begin
                state_q <= StStopPend;
              end else begin
                pc_q <= pc_q + AW'(1);
              end
            end
          end
        end
        StStopPend: begin
          // STOP is speculative until decode takes it; a branch cancels it.
          if (redirect) begin
            pc_q       <= redirect_addr;
            ir_valid_q <= 1'b0;
            state_q    <= StRun;
          end else if (ir_valid_q && ir_ready) begin
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b1;
            state_q    <= StHalted;
          end
        end
        StHalted: begin
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign mem_addr = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign fold_cnt = fold_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational program memory model and
// a tiny execute model for the multiply program.
module tb_fetch_unit;
  import dapa_pkg::*;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_SUBI = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        halted;
  logic [7:0]  fold_cnt;

  logic [15:0] mem [256];

  int n_checks;
  int n_fail;

  fetch_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .fold_cnt      (fold_cnt)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r,
                                      input logic [7:0] imm);
    return {op, r, imm};
  endfunction

  task automatic load_nops();
    for (int i = 0; i < 256; i++) mem[i] = enc(OP_ADD, 3'd2, 8'h00);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves rst_n released at a negedge; the next posedge fetches RESET_PC.
  task automatic apply_reset();
    rst_n         = 1'b0;
    ir_ready      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          exp_q[$];
    int          idx;
    int          cyc;
    logic [7:0]  r1;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    load_nops();

    // ---------------- reset state ----------------
    apply_reset();
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_ir", ir, 0);
    check("rst_halted", halted, 0);
    check("rst_fold_cnt", fold_cnt, 0);

    // ---------------- multiply program ----------------
    load_nops();
    mem[0] = enc(OP_LDI,  3'd0, 8'h08);
    mem[1] = enc(OP_LDI,  3'd1, 8'h10);
    mem[2] = enc(OP_LDI,  3'd2, 8'h00);
    mem[3] = enc(OP_SUBI, 3'd1, 8'h01);
    mem[4] = enc(OPC_BRZS, 3'd1, 8'h07);
    mem[5] = enc(OP_ADD,  3'd2, 8'h00);
    mem[6] = enc(OPC_JMP, 3'd0, 8'h03);
    mem[7] = enc(OP_ADD,  3'd3, 8'h00);
    mem[8] = enc(OPC_STOP, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(3);
      exp_q.push_back(4);
      exp_q.push_back(5);
    end
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(7);
    exp_q.push_back(8);

    apply_reset();
    ir_ready = 1'b1;
    idx = 0;
    cyc = 0;
    r1  = 8'h00;
    while (!halted && cyc < 300) begin
      redirect = 1'b0;
      if (ir_valid && ir_ready) begin
        if (idx < exp_q.size()) check("mul_seq", ir_pc, exp_q[idx]);
        idx++;
        if (ir[15:11] == OP_LDI && ir[10:8] == 3'd1) r1 = ir[7:0];
        if (ir[15:11] == OP_SUBI && ir[10:8] == 3'd1) r1 = r1 - ir[7:0];
        if (ir[15:11] == OPC_BRZS && r1 == 8'h00) begin
          redirect      = 1'b1;
          redirect_addr = ir[7:0];
        end
      end
      step();
      cyc++;
    end
    redirect = 1'b0;
    check("mul_halted", halted, 1);
    check("mul_count", idx, exp_q.size());
    check("mul_fold_cnt", fold_cnt, 8'd15);
    check("mul_ir_valid", ir_valid, 0);
    // Redirect while halted must be ignored.
    redirect      = 1'b1;
    redirect_addr = 8'h03;
    step();
    redirect = 1'b0;
    step();
    check("halt_hold", halted, 1);
    check("halt_pc", mem_addr, 8'h08);
    check("halt_valid", ir_valid, 0);

    // ---------------- stall ----------------
    load_nops();
    apply_reset();
    step();
    check("stall_first", ir_pc, 8'h00);
    ir_ready = 1'b1;
    step();
    check("stall_pre", ir_pc, 8'h01);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ir_pc", ir_pc, 8'h01);
      check("stall_ir", ir, mem[1]);
      check("stall_addr", mem_addr, 8'h02);
      check("stall_valid", ir_valid, 1);
    end
    ir_ready = 1'b1;
    step();
    check("stall_release", ir_pc, 8'h02);

    // ---------------- STOP cancelled by redirect ----------------
    load_nops();
    mem[0] = enc(OPC_STOP, 3'd0, 8'h00);
    apply_reset();
    step();
    check("stop_in_ir", ir_pc, 8'h00);
    step();
    check("stop_pend_valid", ir_valid, 1);
    check("stop_pend_pc", mem_addr, 8'h00);
    redirect      = 1'b1;
    redirect_addr = 8'h05;
    step();
    redirect = 1'b0;
    check("stop_cancel_valid", ir_valid, 0);
    check("stop_cancel_halted", halted, 0);
    step();
    check("stop_cancel_next", ir_pc, 8'h05);
    check("stop_cancel_run", ir_valid, 1);
    check("stop_cancel_halted2", halted, 0);

    // ---------------- redirect with acceptance ----------------
    load_nops();
    apply_reset();
    ir_ready = 1'b1;
    repeat (5) step();
    check("acc_pre", ir_pc, 8'h04);
    redirect      = 1'b1;
    redirect_addr = 8'h07;
    step();
    redirect = 1'b0;
    check("acc_valid", ir_valid, 0);
    step();
    check("acc_next", ir_pc, 8'h07);

    // ---------------- PC wrap ----------------
    load_nops();
    apply_reset();
    ir_ready = 1'b1;
    step();
    redirect      = 1'b1;
    redirect_addr = 8'hFE;
    step();
    redirect = 1'b0;
    step();
    check("wrap_fe", ir_pc, 8'hFE);
    step();
    check("wrap_ff", ir_pc, 8'hFF);
    step();
    check("wrap_00", ir_pc, 8'h00);
    check("wrap_addr", mem_addr, 8'h01);

    // ---------------- asynchronous reset ----------------
    load_nops();
    apply_reset();
    ir_ready = 1'b1;
    repeat (5) step();
    check("arst_pre_pc", mem_addr, 8'h05);
    check("arst_pre_valid", ir_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", ir_valid, 0);
    check("arst_pc", mem_addr, 8'h00);
    check("arst_ir_pc", ir_pc, 8'h00);
    check("arst_ir", ir, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_first", ir_pc, 8'h00);
    check("arst_first_valid", ir_valid, 1);

    // ---------------- JMP to self ----------------
    load_nops();
    mem[0] = enc(OPC_JMP, 3'd0, 8'h00);
    apply_reset();
    ir_ready = 1'b1;
    repeat (3) step();
    check("self_cnt3", fold_cnt, 8'd3);
    check("self_valid", ir_valid, 0);
    repeat (252) step();
    check("self_cnt_ff", fold_cnt, 8'hFF);
    step();
    check("self_cnt_wrap", fold_cnt, 8'h00);
    check("self_pc", mem_addr, 8'h00);
    check("self_valid2", ir_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
